// File: rtl/seven_seg_pkg.sv
// Shared types and sizing helpers for the seven-segment scan driver.
//   seg_t      : segment vector, bit order {g,f,e,d,c,b,a}, active-high (1 = segment on)
//   SEG_BLANK  : all segments off
//   cnt_width  : width of the per-slot cycle counter
//   idx_width  : width of the digit index (at least one bit)
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  // A one-cycle slot would give $clog2 of zero, so keep at least one bit.
  function automatic int cnt_width(input int digit_cycles);
    return (digit_cycles > 1) ? $clog2(digit_cycles) : 1;
  endfunction

  function automatic int idx_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/seven_seg_scan_if.sv
// Display-side bundle of the scan driver.
//   master : source of VALUE / DP_IN / DIGIT_EN / LZ_BLANK, sink of the pin outputs
//   slave  : the scan driver itself
//   VALUE      4*NUM_DIGITS  nibble i = hex digit i, digit 0 rightmost
//   DP_IN      NUM_DIGITS    1 = light decimal point of digit i
//   DIGIT_EN   NUM_DIGITS    1 = digit i may be lit
//   LZ_BLANK   1             1 = suppress leading zeros
//   CA..CG, DP 1 each        cathodes, active-low
//   AN         NUM_DIGITS    anodes, active-low
//   FRAME_DONE 1             one-cycle pulse after each shadow load
interface seven_seg_scan_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] VALUE;
  logic [NUM_DIGITS-1:0]   DP_IN;
  logic [NUM_DIGITS-1:0]   DIGIT_EN;
  logic                    LZ_BLANK;
  logic                    CA, CB, CC, CD, CE, CF, CG;
  logic                    DP;
  logic [NUM_DIGITS-1:0]   AN;
  logic                    FRAME_DONE;

  modport master (
    output VALUE, DP_IN, DIGIT_EN, LZ_BLANK,
    input  CA, CB, CC, CD, CE, CF, CG, DP, AN, FRAME_DONE
  );

  modport slave (
    input  VALUE, DP_IN, DIGIT_EN, LZ_BLANK,
    output CA, CB, CC, CD, CE, CF, CG, DP, AN, FRAME_DONE
  );
endinterface

// File: rtl/bin_to_seven_seg.sv
// Combinational hex nibble to seven-segment decoder.
//   bin_i : 4-bit hex value
//   seg_o : segments {g,f,e,d,c,b,a}, active-high
module bin_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] bin_i,
  output seg_t       seg_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    seg_o = SEG_BLANK;
    case (bin_i)
      4'h0: seg_o = 7'h3F;
      4'h1: seg_o = 7'h06;
      4'h2: seg_o = 7'h5B;
      4'h3: seg_o = 7'h4F;
      4'h4: seg_o = 7'h66;
      4'h5: seg_o = 7'h6D;
      4'h6: seg_o = 7'h7D;
      4'h7: seg_o = 7'h07;
      4'h8: seg_o = 7'h7F;
      4'h9: seg_o = 7'h6F;
      4'hA: seg_o = 7'h77;
      4'hB: seg_o = 7'h7C;
      4'hC: seg_o = 7'h39;
      4'hD: seg_o = 7'h5E;
      4'hE: seg_o = 7'h79;
      4'hF: seg_o = 7'h71;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed common-anode seven-segment driver.
//   CLK100MHZ : system clock
//   RST       : asynchronous active-high reset
//   disp      : display bundle (inputs VALUE/DP_IN/DIGIT_EN/LZ_BLANK, pin outputs)
// Inputs are captured into shadow registers only at frame boundaries (and once
// right after reset), so a frame always shows one consistent value.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic            CLK100MHZ,
  input  logic            RST,
  seven_seg_scan_if.slave disp
);

  localparam int CNT_W = cnt_width(DIGIT_CYCLES);
  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    init_q, init_d;
  logic [4*NUM_DIGITS-1:0] val_sh_q, val_sh_d;
  logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
  logic [NUM_DIGITS-1:0]   en_sh_q, en_sh_d;
  logic                    lz_sh_q, lz_sh_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  seg_t                    seg_n_q, seg_n_d;
  logic                    dp_n_q, dp_n_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_open;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    zero_above;
  logic [3:0]              nib_sel;
  logic                    dp_sel, en_sel, supp_sel;
  seg_t                    seg_sel;
  logic                    lit, load;

  // With no blank interval the comparison would be constant, so drop it.
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign slot_open = 1'b1;
  end else begin : g_blank
    assign slot_open = (cnt_q >= CNT_W'(BLANK_CYCLES));
  end

  // Leading-zero mask from the top digit down, then select the current digit.
  always_comb begin
    zero_above = 1'b1;
    supp       = '0;
    nib_sel    = 4'h0;
    dp_sel     = 1'b0;
    en_sel     = 1'b0;
    supp_sel   = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above & (val_sh_q[4*i +: 4] == 4'h0);
      supp[i]    = lz_sh_q & zero_above & (i != 0);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_sel  = val_sh_q[4*i +: 4];
        dp_sel   = dp_sh_q[i];
        en_sel   = en_sh_q[i];
        supp_sel = supp[i];
      end
    end
  end

  bin_to_seven_seg u_dec (
    .bin_i (nib_sel),
    .seg_o (seg_sel)
  );

  always_comb begin
    lit  = slot_open & en_sel & ~supp_sel;
    load = init_q | ((cnt_q == CNT_LAST) && (idx_q == IDX_LAST));

    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    val_sh_d = val_sh_q;
    dp_sh_d  = dp_sh_q;
    en_sh_d  = en_sh_q;
    lz_sh_d  = lz_sh_q;
    if (load) begin
      val_sh_d = disp.VALUE;
      dp_sh_d  = disp.DP_IN;
      en_sh_d  = disp.DIGIT_EN;
      lz_sh_d  = disp.LZ_BLANK;
    end
    init_d       = 1'b0;
    frame_done_d = load;

    for (int i = 0; i < NUM_DIGITS; i++) begin
      an_d[i] = ~(lit && (idx_q == IDX_W'(i)));
    end
    seg_n_d = lit ? ~seg_sel : ~SEG_BLANK;
    dp_n_d  = ~(lit & dp_sel);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      init_q       <= 1'b1;
      val_sh_q     <= '0;
      dp_sh_q      <= '0;
      en_sh_q      <= '0;
      lz_sh_q      <= 1'b0;
      an_q         <= '1;
      seg_n_q      <= '1;
      dp_n_q       <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      init_q       <= init_d;
      val_sh_q     <= val_sh_d;
      dp_sh_q      <= dp_sh_d;
      en_sh_q      <= en_sh_d;
      lz_sh_q      <= lz_sh_d;
      an_q         <= an_d;
      seg_n_q      <= seg_n_d;
      dp_n_q       <= dp_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign disp.CA         = seg_n_q[0];
  assign disp.CB         = seg_n_q[1];
  assign disp.CC         = seg_n_q[2];
  assign disp.CD         = seg_n_q[3];
  assign disp.CE         = seg_n_q[4];
  assign disp.CF         = seg_n_q[5];
  assign disp.CG         = seg_n_q[6];
  assign disp.DP         = dp_n_q;
  assign disp.AN         = an_q;
  assign disp.FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Directed bench for seven_seg_scan with NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2.
// Outputs are sampled on the falling edge; each slot is checked cycle by cycle.
module tb_seven_seg_scan;

  localparam int ND = 4;
  localparam int DC = 8;
  localparam int BC = 2;

  // Cathode patterns CG..CA, active-low.
  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] SA = 7'b0001000;
  localparam logic [6:0] SB = 7'b0000011;
  localparam logic [6:0] SC = 7'b1000110;
  localparam logic [6:0] SD = 7'b0100001;
  localparam logic [6:0] SOFF = 7'b1111111;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  seven_seg_scan_if #(.NUM_DIGITS(ND)) disp ();

  seven_seg_scan #(
    .NUM_DIGITS   (ND),
    .DIGIT_CYCLES (DC),
    .BLANK_CYCLES (BC)
  ) dut (
    .CLK100MHZ (clk),
    .RST       (rst),
    .disp      (disp.slave)
  );

  always #5 clk = ~clk;

  logic [6:0] segs;
  assign segs = {disp.CG, disp.CF, disp.CE, disp.CD, disp.CC, disp.CB, disp.CA};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Checks cycles lo..hi of one digit slot; first marks the slot after reset release.
  task automatic check_slot(input int digit, input bit lit, input logic [6:0] seg,
                            input bit dp, input bit first, input int lo, input int hi);
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e;
    logic       fd_e;
    for (int c = lo; c <= hi; c++) begin
      tick();
      if (lit && c >= BC) begin
        an_e  = ~(4'(1) << digit);
        seg_e = seg;
        dp_e  = ~dp;
      end else begin
        an_e  = 4'hF;
        seg_e = SOFF;
        dp_e  = 1'b1;
      end
      fd_e = ((c == DC - 1) && (digit == ND - 1)) || (first && c == 0);
      chk($sformatf("AN d%0d c%0d", digit, c), 8'(disp.AN), 8'(an_e));
      chk($sformatf("SEG d%0d c%0d", digit, c), 8'(segs), 8'(seg_e));
      chk($sformatf("DP d%0d c%0d", digit, c), 8'(disp.DP), 8'(dp_e));
      chk($sformatf("FRAME_DONE d%0d c%0d", digit, c), 8'(disp.FRAME_DONE), 8'(fd_e));
    end
  endtask

  task automatic slot(input int digit, input bit lit, input logic [6:0] seg,
                      input bit dp, input bit first);
    check_slot(digit, lit, seg, dp, first, 0, DC - 1);
  endtask

  // Anode exclusivity and dark-when-off, every cycle.
  always @(negedge clk) begin
    n_vec++;
    assert ($countones(~disp.AN) <= 1 &&
            (disp.AN != 4'hF || (segs == SOFF && disp.DP == 1'b1))) else begin
      n_err++;
      $error("FAIL invariant: AN %b segs %b DP %b", disp.AN, segs, disp.DP);
    end
  end

  initial begin
    disp.VALUE    = 16'h1234;
    disp.DIGIT_EN = 4'hF;
    disp.DP_IN    = 4'h0;
    disp.LZ_BLANK = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("reset AN", 8'(disp.AN), 8'h0F);
    chk("reset SEG", 8'(segs), 8'(SOFF));
    chk("reset DP", 8'(disp.DP), 8'h01);
    chk("reset FRAME_DONE", 8'(disp.FRAME_DONE), 8'h00);
    rst = 1'b0;

    // Frame 1: scan order 1234.
    slot(0, 1'b1, S4, 1'b0, 1'b1);
    slot(1, 1'b1, S3, 1'b0, 1'b0);
    slot(2, 1'b1, S2, 1'b0, 1'b0);
    slot(3, 1'b1, S1, 1'b0, 1'b0);

    // Frame 2: VALUE changes mid digit-1 slot, frame keeps showing 1234.
    slot(0, 1'b1, S4, 1'b0, 1'b0);
    check_slot(1, 1'b1, S3, 1'b0, 1'b0, 0, 3);
    disp.VALUE = 16'hABCD;
    check_slot(1, 1'b1, S3, 1'b0, 1'b0, 4, DC - 1);
    slot(2, 1'b1, S2, 1'b0, 1'b0);
    slot(3, 1'b1, S1, 1'b0, 1'b0);

    // Frame 3: ABCD; queue leading-zero pattern for the next frame.
    disp.VALUE    = 16'h0050;
    disp.LZ_BLANK = 1'b1;
    slot(0, 1'b1, SD, 1'b0, 1'b0);
    slot(1, 1'b1, SC, 1'b0, 1'b0);
    slot(2, 1'b1, SB, 1'b0, 1'b0);
    slot(3, 1'b1, SA, 1'b0, 1'b0);

    // Frame 4: 0050 with suppression, upper two digits dark.
    disp.LZ_BLANK = 1'b0;
    slot(0, 1'b1, S0, 1'b0, 1'b0);
    slot(1, 1'b1, S5, 1'b0, 1'b0);
    slot(2, 1'b0, SOFF, 1'b0, 1'b0);
    slot(3, 1'b0, SOFF, 1'b0, 1'b0);

    // Frame 5: 0050 without suppression, all lit.
    disp.VALUE    = 16'h1234;
    disp.DIGIT_EN = 4'b0101;
    disp.DP_IN    = 4'b0100;
    slot(0, 1'b1, S0, 1'b0, 1'b0);
    slot(1, 1'b1, S5, 1'b0, 1'b0);
    slot(2, 1'b1, S0, 1'b0, 1'b0);
    slot(3, 1'b1, S0, 1'b0, 1'b0);

    // Frame 6: only digits 0 and 2, DP on digit 2.
    slot(0, 1'b1, S4, 1'b0, 1'b0);
    slot(1, 1'b0, SOFF, 1'b0, 1'b0);
    slot(2, 1'b1, S2, 1'b1, 1'b0);
    slot(3, 1'b0, SOFF, 1'b0, 1'b0);

    // Frame 7: reset inside digit 2's lit window blanks at once.
    slot(0, 1'b1, S4, 1'b0, 1'b0);
    slot(1, 1'b0, SOFF, 1'b0, 1'b0);
    check_slot(2, 1'b1, S2, 1'b1, 1'b0, 0, 3);
    #1 rst = 1'b1;
    #1;
    chk("midslot reset AN", 8'(disp.AN), 8'h0F);
    chk("midslot reset SEG", 8'(segs), 8'(SOFF));
    chk("midslot reset DP", 8'(disp.DP), 8'h01);
    chk("midslot reset FRAME_DONE", 8'(disp.FRAME_DONE), 8'h00);
    @(negedge clk);
    rst = 1'b0;

    // Restart from digit 0 with blank interval and a single init pulse.
    slot(0, 1'b1, S4, 1'b0, 1'b1);
    slot(1, 1'b0, SOFF, 1'b0, 1'b0);
    slot(2, 1'b1, S2, 1'b1, 1'b0);
    slot(3, 1'b0, SOFF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed driver for an N-digit common-anode seven-segment display, active-low anodes and cathodes, Nexys-style.
- Each digit is shown as a hex nibble from a packed input bus. Includes:
  - per-digit enable
  - per-digit decimal point
  - optional leading-zero suppression
  - an anti-ghosting blank interval
- The displayed value updates only at frame boundaries, so a digit is never torn mid-frame. It replaces the static all-digits-on display path.

Parameters:
- NUM_DIGITS, 8, number of digits scanned; legal range 1..16.
- DIGIT_CYCLES, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be > BLANK_CYCLES.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; legal range 0..DIGIT_CYCLES-1.

Ports:
- CLK100MHZ  input  1  system clock.
- RST  input  1  reset, asynchronous, active-high.
- VALUE  input  4*NUM_DIGITS  nibble i = hex digit i; digit 0 is the rightmost.
- DP_IN  input  NUM_DIGITS  1 = light the decimal point of digit i.
- DIGIT_EN  input  NUM_DIGITS  1 = digit i may be lit.
- LZ_BLANK  input  1  1 = suppress leading zeros.
- CA,CB,CC,CD,CE,CF,CG  output  1 each  segment cathodes, active-low.
- DP  output  1  decimal-point cathode, active-low.
- AN  output  NUM_DIGITS  anodes, active-low.
- FRAME_DONE  output  1  one-cycle pulse at each frame boundary (shadow load).

Behaviour:
- Reset (async, RST=1):
  - AN all 1, CA..CG=1, DP=1, FRAME_DONE=0.
  - slot counter cnt=0, digit index idx=0.
  - shadow registers (value, dp, en, lz) = 0.
  - init flag set.
- Slot counter:
  - cnt counts 0..DIGIT_CYCLES-1.
  - At cnt==DIGIT_CYCLES-1, cnt goes to 0 and idx goes to idx+1.
  - idx wraps NUM_DIGITS-1 -> 0.
- Frame boundary and shadow load:
  - The frame boundary is the cycle where cnt==DIGIT_CYCLES-1 and idx==NUM_DIGITS-1.
  - On that cycle, every shadow register loads from its input and FRAME_DONE=1 on the next cycle.
  - The first rising edge after RST deasserts also loads the shadows (init load), pulses FRAME_DONE, and clears the init flag. If that edge is also a boundary, there is one load and one pulse.
- Display state: all decode uses the shadows only. Input changes mid-frame have no visible effect until the next frame.
- Leading-zero suppression: when shadow lz=1, digit i is suppressed if it is not digit 0 and its nibble and every higher-index nibble are 0. Digit 0 is never suppressed.
- Digit lit condition: digit idx is lit when all of the following hold:
  - cnt >= BLANK_CYCLES
  - shadow en[idx]=1
  - digit idx is not suppressed
- Output latency:
  - Outputs are registered, one cycle after the cnt/idx state they reflect.
  - When lit: AN has only bit idx = 0; segments = ~decode(nibble idx); DP = ~dp[idx].
  - Otherwise: AN all 1, segments all 1, DP 1.
- Brightness: disabled or suppressed digits still consume their slot, so the duty cycle per digit is constant (1/NUM_DIGITS × (DIGIT_CYCLES-BLANK_CYCLES)/DIGIT_CYCLES).
- Anode exclusivity: at most one AN bit is 0 in any cycle.
- Decode: hex 0..F, with segment bit order {g,f,e,d,c,b,a} active-high before inversion.
- NUM_DIGITS=1: idx stays 0 and every slot end is a frame boundary.
- BLANK_CYCLES=0: there is no blank interval.
- Reset mid-slot: outputs blank immediately (asynchronously), and scanning restarts at digit 0, cnt 0.

Decomposition:
- Package seven_seg_pkg:
  - typedef seg_t (logic [6:0], order {g..a}).
  - localparam SEG_BLANK = 7'h00.
  - function for counter width: $clog2(DIGIT_CYCLES).
  - function for idx width: max(1,$clog2(NUM_DIGITS)).
- Sub-module: the existing combinational bin_to_seven_seg nibble decoder, instantiated once on the muxed nibble.
- Leading-zero mask is a combinational loop over the shadow value inside seven_seg_scan.

Test Plan:
Bench parameters are NUM_DIGITS=4, DIGIT_CYCLES=8, BLANK_CYCLES=2.
- Scan order: VALUE=16'h1234, DIGIT_EN=4'hF, LZ=0 -> AN cycles 1110,1101,1011,0111, each low for 6 of 8 cycles. Segments per digit: 4→CG..CA=7'b0011001, 3→0110000, 2→0100100, 1→1111001.
- Frame update: change VALUE to 16'hABCD in the middle of digit 1's slot -> the rest of the frame still shows 1234; after the FRAME_DONE pulse, digit 0 shows D (7'b0100001).
- Leading zeros: VALUE=16'h0050, LZ_BLANK=1 -> digits 3 and 2 keep AN all 1 for their slots, digit 1 shows 5, digit 0 shows 0. With LZ_BLANK=0, all four digits are lit.
- Enable/DP: DIGIT_EN=4'b0101, DP_IN=4'b0100 -> only digits 0 and 2 are lit, and DP=0 only during digit 2's lit cycles.
- Reset mid-slot: assert RST during digit 2's lit window -> the same cycle gives AN=4'hF, CA..CG=1, DP=1. After release, FRAME_DONE pulses once and scanning restarts at digit 0 with the blank interval.
- Invariant: assert every cycle that AN has at most one zero and that CA..CG/DP are all 1 whenever AN==all ones.
